// File: rtl/bubble_corrector_pipe.sv
// Pipelined flash-ADC bubble corrector: majority-window bubble suppression,
// thermometer validity checks and ones-count encoding, 3-cycle latency.
// Optional bubble statistics are enabled with the BUBBLE_STATS_EN macro.
module bubble_corrector_pipe #(
  parameter int unsigned N     = 255,
  parameter int unsigned WIN   = 3,
  parameter int unsigned OUT_W = $clog2(N + 1),
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     therm_in,
  output logic             out_valid,
  output logic [N-1:0]     therm_clean,
  output logic [OUT_W-1:0] code,
  output logic             bubble_raw,
  output logic             bubble_residual,
  output logic             ovr,
  output logic             unr,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic             bubble_sticky
);

  // Half-window: number of neighbours examined on each side of a bit.
  localparam int unsigned HALF = (WIN - 1) / 2;
  localparam int unsigned EXT_W = N + 2 * HALF;

  // Reject unsupported window sizes at elaboration.
  if (WIN != 3 && WIN != 5) begin : g_bad_win
    $error("bubble_corrector_pipe: WIN must be 3 or 5");
  end

  logic             s1_valid;
  logic [N-1:0]     s1_data;
  logic             s2_valid;
  logic [N-1:0]     s2_clean;
  logic             s2_raw;

  logic [EXT_W-1:0] ext_c;
  logic [N-1:0]     clean_c;
  logic             raw_c;
  logic [OUT_W-1:0] ones_c;
  logic             residual_c;

  // S1: capture the raw comparator word.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_data  <= therm_in;
    end
  end

  // Pad with virtual ones below bit 0 and virtual zeros above bit N-1.
  assign ext_c = {{HALF{1'b0}}, s1_data, {HALF{1'b1}}};

  // Majority vote over each window; ext_c[i+k] maps to therm bit i+k-HALF.
  always_comb begin
    logic [2:0] votes;
    clean_c = '0;
    votes   = '0;
    for (int i = 0; i < int'(N); i++) begin
      votes = '0;
      for (int k = 0; k < int'(WIN); k++) begin
        votes = votes + 3'(ext_c[i + k]);
      end
      clean_c[i] = (votes >= 3'(HALF + 1));
    end
  end

  // A set bit sitting above a clear bit breaks the thermometer property.
  assign raw_c = |(s1_data[N-1:1] & ~s1_data[N-2:0]);

  // S2: register the filtered word and the raw-bubble flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_clean <= '0;
      s2_raw   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_clean <= clean_c;
      s2_raw   <= raw_c;
    end
  end

  // Ones-count of the corrected word.
  always_comb begin
    ones_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      ones_c = ones_c + OUT_W'(s2_clean[i]);
    end
  end

  assign residual_c = |(s2_clean[N-1:1] & ~s2_clean[N-2:0]);

  // S3: register code, corrected word and flags onto the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      therm_clean     <= '0;
      code            <= '0;
      bubble_raw      <= 1'b0;
      bubble_residual <= 1'b0;
      ovr             <= 1'b0;
      unr             <= 1'b0;
    end else begin
      out_valid       <= s2_valid;
      therm_clean     <= s2_clean;
      code            <= ones_c;
      bubble_raw      <= s2_raw;
      bubble_residual <= residual_c;
      ovr             <= &s2_clean;
      unr             <= ~|s2_clean;
    end
  end

`ifdef BUBBLE_STATS_EN
  // Saturating bubble counter and sticky flag; a clear beats a same-cycle hit.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      bubble_cnt    <= '0;
      bubble_sticky <= 1'b0;
    end else if (out_valid && bubble_raw) begin
      if (bubble_cnt != {CNT_W{1'b1}}) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
      bubble_sticky <= 1'b1;
    end
  end
`else
  // Statistics disabled: outputs held at zero, clear input ignored.
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign bubble_cnt      = '0;
  assign bubble_sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_bubble_corrector_pipe.sv
// Self-checking bench for bubble_corrector_pipe (N=15, WIN=3 and WIN=5 side by side).
module tb_bubble_corrector_pipe;

  localparam int NB = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [NB-1:0]   therm_in;
  logic            stat_clr;

  logic            ov3, br3, bres3, ovr3, unr3, bs3;
  logic [NB-1:0]   tc3;
  logic [3:0]      code3;
  logic [1:0]      bc3;
  logic            ov5, br5, bres5, ovr5, unr5, bs5;
  logic [NB-1:0]   tc5;
  logic [3:0]      code5;
  logic [1:0]      bc5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bubble_corrector_pipe #(.N(NB), .WIN(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .therm_in(therm_in),
    .out_valid(ov3), .therm_clean(tc3), .code(code3), .bubble_raw(br3),
    .bubble_residual(bres3), .ovr(ovr3), .unr(unr3), .stat_clr(stat_clr),
    .bubble_cnt(bc3), .bubble_sticky(bs3));

  bubble_corrector_pipe #(.N(NB), .WIN(5), .CNT_W(2)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .therm_in(therm_in),
    .out_valid(ov5), .therm_clean(tc5), .code(code5), .bubble_raw(br5),
    .bubble_residual(bres5), .ovr(ovr5), .unr(unr5), .stat_clr(stat_clr),
    .bubble_cnt(bc5), .bubble_sticky(bs5));

  // ---------------- reference model ----------------
  function automatic int vbit(input logic [NB-1:0] x, input int j);
    if (j < 0) return 1;
    if (j >= NB) return 0;
    return int'(x[j]);
  endfunction

  function automatic logic [NB-1:0] model_clean(input logic [NB-1:0] x, input int win);
    logic [NB-1:0] r;
    int h;
    int cnt;
    h = (win - 1) / 2;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      cnt = 0;
      for (int j = i - h; j <= i + h; j++) cnt += vbit(x, j);
      r[i] = (cnt * 2 > win);
    end
    return r;
  endfunction

  function automatic int popc(input logic [NB-1:0] x);
    int p;
    p = 0;
    for (int i = 0; i < NB; i++) p += int'(x[i]);
    return p;
  endfunction

  // A word is a thermometer code iff it equals 2^popcount - 1.
  function automatic bit is_therm(input logic [NB-1:0] x);
    logic [NB:0] m;
    m = (17'(1) << popc(x)) - 17'(1);
    return x == m[NB-1:0];
  endfunction

  // Drive one sample for a cycle and count edges until out_valid (dut3) rises.
  task automatic send_and_wait(input logic [NB-1:0] d, output int lat);
    in_valid = 1'b1;
    therm_in = d;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (ov3) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; therm_in = '0; stat_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ov3, tc3, code3, br3, bres3, ovr3, unr3, bc3, bs3} !== '0) begin
      errors++;
      $display("FAIL reset_outputs3: got ov=%b tc=%h code=%0d flags=%b%b%b%b cnt=%0d st=%b, want all 0",
               ov3, tc3, code3, br3, bres3, ovr3, unr3, bc3, bs3);
    end
    checks++;
    if ({ov5, tc5, code5, br5, bres5, ovr5, unr5, bc5, bs5} !== '0) begin
      errors++;
      $display("FAIL reset_outputs5: got ov=%b tc=%h code=%0d, want all 0", ov5, tc5, code5);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_single_bubble;
    int lat;
    send_and_wait(15'h00F7, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL latency: got %0d want 3", lat); end
    checks++;
    if (tc3 !== 15'h00FF || code3 !== 4'd8 || br3 !== 1'b1 || bres3 !== 1'b0) begin
      errors++;
      $display("FAIL bubble_f7: got tc=%h code=%0d raw=%b res=%b want 00ff 8 1 0", tc3, code3, br3, bres3);
    end
    idle(2);
    send_and_wait(15'h04FF, lat);
    checks++;
    if (lat !== 3 || tc3 !== 15'h00FF || code3 !== 4'd8 || br3 !== 1'b1) begin
      errors++;
      $display("FAIL isolated_high: got lat=%0d tc=%h code=%0d raw=%b want 3 00ff 8 1", lat, tc3, code3, br3);
    end
    idle(2);
  endtask

  task automatic test_double_bubble;
    int lat;
    send_and_wait(15'h00E7, lat);
    checks++;
    if (lat !== 3 || tc3 !== 15'h00E7 || code3 !== 4'd6 || bres3 !== 1'b1) begin
      errors++;
      $display("FAIL double_win3: got lat=%0d tc=%h code=%0d res=%b want 3 00e7 6 1", lat, tc3, code3, bres3);
    end
    checks++;
    if (ov5 !== 1'b1 || tc5 !== 15'h00FF || code5 !== 4'd8 || bres5 !== 1'b0) begin
      errors++;
      $display("FAIL double_win5: got ov=%b tc=%h code=%0d res=%b want 1 00ff 8 0", ov5, tc5, code5, bres5);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [NB-1:0] seq [3];
    seq[0] = 15'h7FFF; seq[1] = 15'h0000; seq[2] = 15'h0001;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; therm_in = seq[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (ov3 !== 1'b1 || code3 !== 4'd15 || ovr3 !== 1'b1 || unr3 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: got ov=%b code=%0d ovr=%b unr=%b want 1 15 1 0", ov3, code3, ovr3, unr3);
    end
    @(posedge clk); #1;
    checks++;
    if (ov3 !== 1'b1 || code3 !== 4'd0 || unr3 !== 1'b1 || ovr3 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: got ov=%b code=%0d ovr=%b unr=%b want 1 0 0 1", ov3, code3, ovr3, unr3);
    end
    @(posedge clk); #1;
    checks++;
    if (ov3 !== 1'b1 || code3 !== 4'd1 || {ovr3, unr3, br3, bres3} !== 4'b0) begin
      errors++;
      $display("FAIL b2b_one: got ov=%b code=%0d flags=%b%b%b%b want 1 1 0000", ov3, code3, ovr3, unr3, br3, bres3);
    end
    @(posedge clk); #1;
    checks++;
    if (ov3 !== 1'b0) begin errors++; $display("FAIL b2b_tail: got ov=%b want 0", ov3); end
    idle(2);
  endtask

  task automatic test_mid_reset;
    bit seen;
    in_valid = 1'b1; therm_in = 15'h7FFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({ov3, tc3, code3, br3, bres3, ovr3, unr3, bc3, bs3} !== '0) begin
      errors++;
      $display("FAIL mid_reset_zero: got ov=%b tc=%h code=%0d ovr=%b want all 0", ov3, tc3, code3, ovr3);
    end
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ov3 || ov5) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_discard: got out_valid after reset, want none"); end
  endtask

  task automatic test_random(input int n);
    logic          qv [$];
    logic [NB-1:0] qd [$];
    logic          ev;
    logic [NB-1:0] ed, e3, e5;
    int            shift;
    for (int it = 0; it < n + 3; it++) begin
      @(posedge clk); #1;
      if (qv.size() == 3) begin
        ev = qv.pop_front();
        ed = qd.pop_front();
        checks++;
        if (ov3 !== ev || ov5 !== ev) begin
          errors++;
          $display("FAIL rand_valid: got %b/%b want %b", ov3, ov5, ev);
        end
        if (ev) begin
          e3 = model_clean(ed, 3);
          e5 = model_clean(ed, 5);
          checks++;
          if (tc3 !== e3 || code3 !== 4'(popc(e3)) || br3 !== !is_therm(ed) ||
              bres3 !== !is_therm(e3) || ovr3 !== (popc(e3) == NB) || unr3 !== (popc(e3) == 0)) begin
            errors++;
            $display("FAIL rand_win3: in=%h got tc=%h code=%0d raw=%b res=%b want tc=%h code=%0d raw=%b res=%b",
                     ed, tc3, code3, br3, bres3, e3, popc(e3), !is_therm(ed), !is_therm(e3));
          end
          checks++;
          if (tc5 !== e5 || code5 !== 4'(popc(e5)) || br5 !== !is_therm(ed) ||
              bres5 !== !is_therm(e5) || ovr5 !== (popc(e5) == NB) || unr5 !== (popc(e5) == 0)) begin
            errors++;
            $display("FAIL rand_win5: in=%h got tc=%h code=%0d res=%b want tc=%h code=%0d res=%b",
                     ed, tc5, code5, bres5, e5, popc(e5), !is_therm(e5));
          end
        end
      end
      if (it < n) begin
        shift = int'($urandom_range(0, NB));
        in_valid = ($urandom_range(0, 3) != 0);
        therm_in = 15'((32'd1 << shift) - 32'd1);
        if ($urandom_range(0, 1) == 1) therm_in = therm_in ^ (15'(1) << $urandom_range(0, NB - 1));
        if ($urandom_range(0, 3) == 0) therm_in = therm_in ^ (15'(1) << $urandom_range(0, NB - 1));
      end else begin
        in_valid = 1'b0;
      end
      qv.push_back(in_valid);
      qd.push_back(therm_in);
    end
    in_valid = 1'b0;
    idle(3);
  endtask

`ifdef BUBBLE_STATS_EN
  task automatic test_stats;
    int lat;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; therm_in = 15'h00F7;
      @(posedge clk); #1;
    end
    idle(6);
    checks++;
    if (bc3 !== 2'd3 || bs3 !== 1'b1) begin
      errors++;
      $display("FAIL stats_saturate: got cnt=%0d sticky=%b want 3 1", bc3, bs3);
    end
    send_and_wait(15'h00F7, lat);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    checks++;
    if (lat !== 3 || bc3 !== 2'd0 || bs3 !== 1'b0) begin
      errors++;
      $display("FAIL stats_clear_wins: got lat=%0d cnt=%0d sticky=%b want 3 0 0", lat, bc3, bs3);
    end
  endtask
`else
  task automatic test_stats;
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    checks++;
    if (bc3 !== 2'd0 || bs3 !== 1'b0 || bc5 !== 2'd0 || bs5 !== 1'b0) begin
      errors++;
      $display("FAIL stats_disabled: got cnt=%0d sticky=%b want 0 0", bc3, bs3);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_bubble();
    test_double_bubble();
    test_back_to_back();
    test_mid_reset();
    test_random(400);
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bubble_corrector_pipe.md
Name: bubble_corrector_pipe

Overview:
- Pipelined, parametrised successor to the combinational flash-ADC bubble corrector.
- Takes the raw N-bit comparator thermometer word from the comparator bank and performs majority-window bubble suppression (3- or 5-tap), validity checking and thermometer-to-binary (ones-count) encoding.
- Output is a registered code with a valid strobe; sits between the comparator latch stage and the ADC output/decimation logic.

Parameters:
- N, 255, number of comparator outputs (thermometer width, N >= 5).
- WIN, 3, majority window size; legal values 3 or 5, any other value is an elaboration error.
- OUT_W, $clog2(N+1), binary code width.
- CNT_W, 16, bubble statistics counter width.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  therm_in is a new sample this cycle.
- therm_in  in  N  raw thermometer word; bit 0 is the lowest threshold.
- out_valid  out  1  code/therm_clean/flags valid this cycle.
- therm_clean  out  N  corrected thermometer word.
- code  out  OUT_W  number of ones in therm_clean.
- bubble_raw  out  1  the sample's therm_in was not a valid thermometer code.
- bubble_residual  out  1  therm_clean is still not a valid thermometer code.
- ovr  out  1  therm_clean all ones.
- unr  out  1  therm_clean all zeros.
- stat_clr  in  1  clears statistics (optional feature).
- bubble_cnt  out  CNT_W  saturating count of bubble_raw samples (optional feature).
- bubble_sticky  out  1  sticky bubble_raw indicator (optional feature).

Behaviour:
- Valid thermometer code: no index i with bit[i]=1 and bit[i-1]=0.
- Pipeline: free-running, no backpressure. Stage valid bits shift every cycle.
  - S1: register therm_in and in_valid.
  - S2: majority filter, raw-bubble check; register.
  - S3: ones-count, residual check, ovr/unr; register to outputs.
- Latency: exactly 3 clk from in_valid sample edge to out_valid. Throughput 1 sample/clk.
- Majority: clean[i] = 1 iff at least ceil(WIN/2) bits of window in[i-(WIN-1)/2 .. i+(WIN-1)/2] are 1.
  - Virtual bits below index 0 are 1; virtual bits at index N and above are 0.
  - For WIN=3: clean[0] = in[0]|in[1] and clean[N-1] = in[N-2]&in[N-1].
- code: popcount of therm_clean, range 0..N, fits OUT_W with no overflow.
- Stages holding in_valid=0 still propagate data. Outputs update every cycle; consumers qualify with out_valid.
- Reset (any cycle, including mid-pipeline): next edge clears all stage valids, out_valid=0, therm_clean=0, code=0, all flags=0, bubble_cnt=0, bubble_sticky=0. In-flight samples are discarded. A sample presented in the reset cycle is lost.
- in_valid asserted in consecutive cycles yields out_valid in consecutive cycles, in order.

Optional Feature:
- Macro: BUBBLE_STATS_EN.
- Defined:
  - bubble_cnt increments by 1 on each out_valid cycle with bubble_raw=1, saturating at 2^CNT_W-1.
  - bubble_sticky sets on the same event and holds until cleared.
  - stat_clr=1 clears both at the next edge. If stat_clr and an increment occur in the same cycle, the clear wins: result 0, not 1.
- Not defined: bubble_cnt and bubble_sticky are tied to 0, stat_clr is ignored, and the ports remain present.

Test Plan:
- N=15, WIN=3, in_valid pulse with therm_in=0x00F7 -> 3 clk later out_valid=1, therm_clean=0x00FF, code=8, bubble_raw=1, bubble_residual=0.
- N=15, WIN=3, therm_in=0x04FF (isolated high at bit 10) -> therm_clean=0x00FF, code=8, bubble_raw=1.
- N=15, therm_in=0x00E7 (double bubble): WIN=3 -> therm_clean=0x00E7, code=6, bubble_residual=1; WIN=5 -> therm_clean=0x00FF, code=8, bubble_residual=0.
- N=15, back-to-back 0x7FFF, 0x0000, 0x0001 -> three consecutive out_valid cycles: code=15 with ovr=1; code=0 with unr=1; code=1 with flags clear.
- rst=1 asserted one cycle after in_valid while the sample is in S2 -> out_valid never asserts for it; all outputs 0 the cycle after reset.
- BUBBLE_STATS_EN, CNT_W=2, five bubbled samples -> bubble_cnt=3 (saturated), bubble_sticky=1. stat_clr coincident with a sixth bubble -> bubble_cnt=0, bubble_sticky=0.
